// File: rtl/main_src.sv
// main_src: hidden-vector post-processing unit.
// It applies load, ReLU, saturating accumulate or halve to DATA_N lanes per cycle.
module main_src #(
    parameter int BIT_LENGTH = 16,
    parameter int HID_LENGTH = 24,
    parameter int DATA_N     = 6
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             run,
    input  logic [1:0]                       selecter,
    input  logic [4*BIT_LENGTH*DATA_N-1:0]   data_in,
    output logic                             valid,
    output logic [HID_LENGTH*BIT_LENGTH-1:0] data_out
);
    localparam int W  = BIT_LENGTH;
    localparam int G  = HID_LENGTH / DATA_N;
    localparam int CW = $clog2(G);
    localparam int AW = $clog2(HID_LENGTH * BIT_LENGTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                      state_q;
    logic [CW-1:0]               cnt_q;
    logic [1:0]                  sel_q;
    logic                        valid_q;
    logic [HID_LENGTH*W-1:0]     in_q;
    logic [HID_LENGTH*W-1:0]     out_q;
    logic [DATA_N*W-1:0]         grp_d;
    logic [AW-1:0]               base;

    assign base = AW'(cnt_q) * AW'(DATA_N * W);

    // One adder/saturator per lane of the active group, shared across groups.
    for (genvar j = 0; j < DATA_N; j++) begin : g_lane
        localparam logic [AW-1:0] OFF = AW'(j * W);
        logic signed [W-1:0] x, y;
        logic signed [W:0]   s;
        assign x = in_q[base + OFF +: W];
        assign y = out_q[base + OFF +: W];
        assign s = {x[W-1], x} + {y[W-1], y};
        assign grp_d[j*W +: W] =
            sel_q == 2'd0 ? x :
            sel_q == 2'd1 ? (x[W-1] ? '0 : x) :
            sel_q == 2'd2 ? (s[W] != s[W-1] ? {s[W], {(W-1){~s[W]}}} : s[W-1:0]) :
                            {x[W-1], x[W-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            in_q    <= '0;
            out_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (run) begin
                        in_q    <= data_in;
                        sel_q   <= selecter;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    out_q[base +: DATA_N*W] <= grp_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(G - 1)) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid    = valid_q;
    assign data_out = out_q;
endmodule

// File: tb/tb_main_src.sv
// tb_main_src: directed self-checking bench for main_src.
module tb_main_src;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         run;
    logic [1:0]   selecter;
    logic [383:0] data_in;
    logic         valid;
    logic [383:0] data_out;
    int           n_chk = 0;
    int           n_pass = 0;

    main_src dut (
        .clk(clk), .rst_n(rst_n), .run(run), .selecter(selecter),
        .data_in(data_in), .valid(valid), .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [15:0] lane(input logic [383:0] v, input int i);
        return v[16*i +: 16];
    endfunction

    // Start an op from a negedge, drop run after capture, return the edge index of valid.
    task automatic do_op(input string tag, input logic [1:0] sel, input logic [383:0] d,
                         input bit disturb, input logic [383:0] exp);
        int lat;
        data_in = d; selecter = sel; run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        if (disturb) begin
            data_in = ~d;
            selecter = ~sel;
        end
        lat = 0;
        while (!valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 384'(lat), 384'd4);
        check({tag, "_data"}, data_out, exp);
        @(negedge clk);
        check({tag, "_pulse"}, 384'(valid), 384'd0);
    endtask

    initial begin
        logic [383:0] d, e;
        int saw;
        rst_n = 1'b0; run = 1'b1; selecter = 2'd2;
        for (int i = 0; i < 12; i++) data_in[32*i +: 32] = $urandom;
        repeat (3) @(negedge clk);
        check("rst_valid", 384'(valid), 384'd0);
        check("rst_data", data_out, '0);

        // LOAD with run held until valid, released together with reset.
        for (int i = 0; i < 24; i++) d[16*i +: 16] = 16'(i + 1);
        data_in = d; selecter = 2'd0; rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("load_e0_l5", 384'(lane(data_out, 5)), 384'd0);
        @(negedge clk);
        check("load_e1_l5", 384'(lane(data_out, 5)), 384'd6);
        check("load_e1_l6", 384'(lane(data_out, 6)), 384'd0);
        @(negedge clk);
        check("load_e2_l6", 384'(lane(data_out, 6)), 384'd7);
        check("load_e2_valid", 384'(valid), 384'd0);
        @(negedge clk);
        check("load_e3_valid", 384'(valid), 384'd0);
        @(negedge clk);
        check("load_e4_valid", 384'(valid), 384'd1);
        check("load_data", data_out, d);
        run = 1'b0;
        @(negedge clk);
        check("load_pulse", 384'(valid), 384'd0);
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            d[16*i +: 16] = i[0] ? 16'hFF00 : 16'h0100;
            e[16*i +: 16] = i[0] ? 16'h0000 : 16'h0100;
        end
        d[16*22 +: 16] = 16'h8000;
        e[16*22 +: 16] = 16'h0000;
        do_op("relu", 2'd1, d, 1'b0, e);

        do_op("ld7000", 2'd0, {24{16'h7000}}, 1'b0, {24{16'h7000}});
        do_op("acc_pos", 2'd2, {24{16'h2000}}, 1'b0, {24{16'h7FFF}});
        do_op("ld9000", 2'd0, {24{16'h9000}}, 1'b0, {24{16'h9000}});
        do_op("acc_neg", 2'd2, {24{16'hE000}}, 1'b0, {24{16'h8000}});
        do_op("ld0010", 2'd0, {24{16'h0010}}, 1'b0, {24{16'h0010}});
        do_op("acc_add", 2'd2, {24{16'h0005}}, 1'b0, {24{16'h0015}});

        d = {24{16'h0064}}; e = {24{16'h0032}};
        d[15:0] = 16'h0003;  e[15:0] = 16'h0001;
        d[31:16] = 16'hFFFF; e[31:16] = 16'hFFFF;
        d[47:32] = 16'h8000; e[47:32] = 16'hC000;
        do_op("half", 2'd3, d, 1'b0, e);

        do_op("disturb", 2'd3, {24{16'h0040}}, 1'b1, {24{16'h0020}});

        // Reset asserted just after E2 of a LOAD aborts it.
        data_in = {24{16'h1111}}; selecter = 2'd0; run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_pre_l0", 384'(lane(data_out, 0)), 384'h1111);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("abort_data", data_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 0;
        repeat (8) begin
            @(negedge clk);
            if (valid) saw++;
        end
        check("abort_novalid", 384'(saw), 384'd0);
        check("abort_hold", data_out, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
